dbg_halt_ctrl: RTL and testbench

//  Debug run-control sequencer for the 3-stage (IF / DE / MW) RV32I pipeline.

---
 rtl/dbg_pkg.sv | 16 +
 rtl/dbg_halt_ctrl.sv | 133 +++++++++++++
 tb/tb_dbg_halt_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_pkg.sv
// Shared types for the debug run-control sequencer: FSM state encoding and dcsr.cause codes.
package dbg_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DRAIN   = 3'd1,
    HALTED  = 3'd2,
    RESUME  = 3'd3,
    STEP    = 3'd4
  } dbg_state_e;

  localparam logic [2:0] CAUSE_EBREAK  = 3'd1;
  localparam logic [2:0] CAUSE_HALTREQ = 3'd3;
  localparam logic [2:0] CAUSE_STEP    = 3'd4;

endpackage

// File: rtl/dbg_halt_ctrl.sv
// Debug run-control sequencer: halt/resume/step for the IF/DE/MW pipeline; DBG_STEP_EN adds single-step.
// Latency: halted rises DRAIN_CYCLES+2 edges after the entry cycle (longer while mw_busy); resume takes 1 cycle.
// Backpressure: mw_busy holds the drain indefinitely; requests are levels, no handshake beyond resumeack.
module dbg_halt_ctrl
  import dbg_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        haltreq,
  input  logic        resumereq,
  input  logic        step,
  input  logic        ebreak_DE,
  input  logic        hz_stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic [31:0] pc_IF,
  input  logic [31:0] pc_DE,
  input  logic        mw_busy,
  output logic        dbg_stall_IF,
  output logic        dbg_flush_DE,
  output logic        pc_redirect,
  output logic [31:0] dpc,
  output logic [2:0]  cause,
  output logic        halted,
  output logic        running,
  output logic        resumeack
);

  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYCLES);

  dbg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       dpc_q, dpc_d;
  logic [2:0]        cause_q, cause_d;

`ifndef DBG_STEP_EN
  logic unused_step;
  assign unused_step = step;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dpc_d   = dpc_q;
    cause_d = cause_q;
    case (state_q)
      RUN: begin
        if (haltreq) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
          cause_d = CAUSE_HALTREQ;
          // A killed DE instruction (ebreak or load-use victim) is the next to execute.
          if (ebreak_DE)     dpc_d = pc_DE;
          else if (br_taken) dpc_d = br_target;
          else if (hz_stall) dpc_d = pc_DE;
          else               dpc_d = pc_IF;
        end else if (ebreak_DE) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LOAD;
          cause_d = CAUSE_EBREAK;
          dpc_d   = pc_DE;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          if (!mw_busy) state_d = HALTED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HALTED: begin
        if (resumereq) state_d = RESUME;
      end
      RESUME: begin
        state_d = RUN;
`ifdef DBG_STEP_EN
        if (step) state_d = STEP;
`endif
      end
`ifdef DBG_STEP_EN
      STEP: begin
        state_d = DRAIN;
        cnt_d   = DRAIN_LOAD;
        if (ebreak_DE) begin
          cause_d = CAUSE_EBREAK;
          dpc_d   = pc_DE;
        end else begin
          cause_d = CAUSE_STEP;
          dpc_d   = br_taken ? br_target : pc_IF;
        end
      end
`endif
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      dpc_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dpc_q   <= dpc_d;
      cause_q <= cause_d;
    end
  end

  // Entry-cycle kills must act in the same cycle, so these two terms bypass the state register.
  logic kill_entry;
  always_comb begin
    kill_entry = 1'b0;
    if (state_q == RUN)  kill_entry = ebreak_DE | (haltreq & hz_stall);
`ifdef DBG_STEP_EN
    if (state_q == STEP) kill_entry = ebreak_DE;
`endif
  end

  assign dbg_stall_IF = (state_q == DRAIN) | (state_q == HALTED);
  assign dbg_flush_DE = dbg_stall_IF | (state_q == RESUME) | kill_entry;
  assign pc_redirect  = (state_q == RESUME);
  assign resumeack    = (state_q == RESUME);
  assign halted       = (state_q == HALTED);
  assign running      = !dbg_stall_IF;
  assign dpc          = dpc_q;
  assign cause        = cause_q;

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Directed bench for dbg_halt_ctrl: halt sources, dpc selection, drain timing, resume, step, reset.
module tb_dbg_halt_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        haltreq, resumereq, step, ebreak_DE, hz_stall, br_taken, mw_busy;
  logic [31:0] br_target, pc_IF, pc_DE;
  logic        dbg_stall_IF, dbg_flush_DE, pc_redirect, halted, running, resumeack;
  logic [31:0] dpc;
  logic [2:0]  cause;

  int total = 0;
  int bad   = 0;

  dbg_halt_ctrl dut (
    .clk(clk), .rst(rst), .haltreq(haltreq), .resumereq(resumereq), .step(step),
    .ebreak_DE(ebreak_DE), .hz_stall(hz_stall), .br_taken(br_taken), .br_target(br_target),
    .pc_IF(pc_IF), .pc_DE(pc_DE), .mw_busy(mw_busy),
    .dbg_stall_IF(dbg_stall_IF), .dbg_flush_DE(dbg_flush_DE), .pc_redirect(pc_redirect),
    .dpc(dpc), .cause(cause), .halted(halted), .running(running), .resumeack(resumeack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counts falling edges until halted; from the cycle after entry the drain takes DRAIN_CYCLES+1 cycles.
  task automatic wait_halt(input string tag, input int exp_n);
    int n = 0;
    while (halted !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n, exp_n);
  endtask

  task automatic do_resume(input string tag);
    resumereq = 1'b1;
    @(negedge clk);
    resumereq = 1'b0;
    chk({tag, "_redirect"}, pc_redirect, 1'b1);
    chk({tag, "_ack"}, resumeack, 1'b1);
    chk({tag, "_flush"}, dbg_flush_DE, 1'b1);
    chk({tag, "_not_halted"}, halted, 1'b0);
    @(negedge clk);
    chk({tag, "_redirect_pulse"}, pc_redirect, 1'b0);
    chk({tag, "_ack_pulse"}, resumeack, 1'b0);
    chk({tag, "_running"}, running, 1'b1);
  endtask

  initial begin
    rst = 1'b1; haltreq = 0; resumereq = 0; step = 0; ebreak_DE = 0; hz_stall = 0;
    br_taken = 0; mw_busy = 0; br_target = 0; pc_IF = 0; pc_DE = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_running", running, 1'b1);
    chk("rst_halted", halted, 1'b0);
    chk("rst_stall", dbg_stall_IF, 1'b0);
    chk("rst_flush", dbg_flush_DE, 1'b0);
    chk("rst_redirect", pc_redirect, 1'b0);
    chk("rst_ack", resumeack, 1'b0);
    chk("rst_dpc", dpc, 32'h0);
    chk("rst_cause", cause, 3'd0);
    @(negedge clk);

    // Plain haltreq, no hazard: dpc from IF, DE not killed.
    pc_IF = 32'h40; pc_DE = 32'h3C; haltreq = 1'b1;
    #1 chk("hreq_entry_flush", dbg_flush_DE, 1'b0);
    @(negedge clk);
    haltreq = 1'b0;
    chk("hreq_drain_stall", dbg_stall_IF, 1'b1);
    chk("hreq_drain_flush", dbg_flush_DE, 1'b1);
    chk("hreq_drain_running", running, 1'b0);
    chk("hreq_drain_halted", halted, 1'b0);
    wait_halt("hreq_drain_len", 3);
    chk("hreq_dpc", dpc, 32'h40);
    chk("hreq_cause", cause, 3'd3);
    chk("hreq_halt_stall", dbg_stall_IF, 1'b1);
    do_resume("res1");

    // ebreak in DE: killed in the same cycle.
    pc_IF = 32'h20; pc_DE = 32'h1C; ebreak_DE = 1'b1;
    #1 chk("ebrk_entry_flush", dbg_flush_DE, 1'b1);
    @(negedge clk);
    ebreak_DE = 1'b0;
    wait_halt("ebrk_drain_len", 3);
    chk("ebrk_dpc", dpc, 32'h1C);
    chk("ebrk_cause", cause, 3'd1);
    do_resume("res2");

    // haltreq with a taken branch: target wins.
    pc_IF = 32'h60; pc_DE = 32'h5C; br_taken = 1'b1; br_target = 32'h200; haltreq = 1'b1;
    @(negedge clk);
    haltreq = 1'b0; br_taken = 1'b0;
    wait_halt("br_drain_len", 3);
    chk("br_dpc", dpc, 32'h200);
    chk("br_cause", cause, 3'd3);
    do_resume("res3");

    // haltreq during load-use stall: DE killed, dpc from DE.
    pc_IF = 32'h28; pc_DE = 32'h24; hz_stall = 1'b1; haltreq = 1'b1;
    #1 chk("hz_entry_flush", dbg_flush_DE, 1'b1);
    @(negedge clk);
    haltreq = 1'b0; hz_stall = 1'b0;
    wait_halt("hz_drain_len", 3);
    chk("hz_dpc", dpc, 32'h24);
    chk("hz_cause", cause, 3'd3);
    do_resume("res4");

    // haltreq together with ebreak: DE pc, haltreq cause.
    pc_IF = 32'h94; pc_DE = 32'h90; haltreq = 1'b1; ebreak_DE = 1'b1; br_taken = 1'b1; br_target = 32'h300;
    #1 chk("both_entry_flush", dbg_flush_DE, 1'b1);
    @(negedge clk);
    haltreq = 1'b0; ebreak_DE = 1'b0; br_taken = 1'b0;
    wait_halt("both_drain_len", 3);
    chk("both_dpc", dpc, 32'h90);
    chk("both_cause", cause, 3'd3);
    do_resume("res5");

    // mw_busy held for 5 drain cycles; branches in drain and haltreq while halted are ignored.
    pc_IF = 32'h100; pc_DE = 32'hFC; haltreq = 1'b1; mw_busy = 1'b1;
    @(negedge clk);
    haltreq = 1'b0; br_taken = 1'b1; br_target = 32'h999;
    for (int i = 0; i < 5; i++) begin
      chk("mw_hold_halted", halted, 1'b0);
      @(negedge clk);
    end
    chk("mw_hold_last", halted, 1'b0);
    mw_busy = 1'b0;
    @(negedge clk);
    br_taken = 1'b0;
    chk("mw_release_halted", halted, 1'b1);
    chk("mw_dpc", dpc, 32'h100);
    haltreq = 1'b1;
    repeat (2) @(negedge clk);
    chk("halted_hreq_ignored", halted, 1'b1);
    chk("halted_dpc_stable", dpc, 32'h100);
    // Resume with haltreq still high: one RUN cycle, then re-halt.
    resumereq = 1'b1;
    @(negedge clk);
    resumereq = 1'b0;
    chk("rehalt_ack", resumeack, 1'b1);
    pc_IF = 32'h104; pc_DE = 32'h100;
    @(negedge clk);
    chk("rehalt_run", running, 1'b1);
    @(negedge clk);
    haltreq = 1'b0;
    chk("rehalt_drain", dbg_stall_IF, 1'b1);
    wait_halt("rehalt_len", 3);
    chk("rehalt_dpc", dpc, 32'h104);

`ifdef DBG_STEP_EN
    do_resume("res6");
    pc_IF = 32'h80; pc_DE = 32'h7C; haltreq = 1'b1;
    @(negedge clk);
    haltreq = 1'b0;
    wait_halt("step_pre_len", 3);
    chk("step_pre_dpc", dpc, 32'h80);
    step = 1'b1; resumereq = 1'b1;
    @(negedge clk);
    resumereq = 1'b0;
    chk("step_redirect", pc_redirect, 1'b1);
    pc_IF = 32'h84; pc_DE = 32'h80;
    @(negedge clk);
    chk("step_open_stall", dbg_stall_IF, 1'b0);
    chk("step_open_flush", dbg_flush_DE, 1'b0);
    @(negedge clk);
    step = 1'b0;
    chk("step_drain_stall", dbg_stall_IF, 1'b1);
    wait_halt("step_drain_len", 3);
    chk("step_dpc", dpc, 32'h84);
    chk("step_cause", cause, 3'd4);
`else
    // Without single-step support, step is ignored and resume always runs.
    step = 1'b1;
    do_resume("nostep");
    @(negedge clk);
    chk("nostep_running", running, 1'b1);
    chk("nostep_stall", dbg_stall_IF, 1'b0);
    step = 1'b0;
    pc_IF = 32'h80; haltreq = 1'b1;
    @(negedge clk);
    haltreq = 1'b0;
    wait_halt("nostep_halt_len", 3);
`endif

    // Reset while halted returns straight to RUN with cleared dpc/cause.
    chk("pre_rst_halted", halted, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_halt_running", running, 1'b1);
    chk("rst_halt_halted", halted, 1'b0);
    chk("rst_halt_dpc", dpc, 32'h0);
    chk("rst_halt_cause", cause, 3'd0);

    // Reset mid-drain discards the pending counter.
    pc_IF = 32'h44; haltreq = 1'b1;
    @(negedge clk);
    haltreq = 1'b0;
    chk("mid_drain", dbg_stall_IF, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_drain_rst_running", running, 1'b1);
    repeat (4) @(negedge clk);
    chk("mid_drain_no_halt", halted, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
